// File: rtl/cvs_io_bank_if.sv
// Pin-side bundle of cvs_io_bank: GPIO in/out, per-channel mode, divider control and edge counts.
interface cvs_io_bank_if #(
    parameter int N_CH  = 5,
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       in_pins;
    logic [N_CH-1:0]       out_pins;
    logic [2*N_CH-1:0]     mode;
    logic [DIV_W-1:0]      div_ratio;
    logic                  div_load;
    logic                  clk_div_out;
    logic [N_CH*CNT_W-1:0] edge_cnt;
    logic                  cnt_clr;

    modport master (
        output in_pins, mode, div_ratio, div_load, cnt_clr,
        input  out_pins, clk_div_out, edge_cnt
    );

    modport slave (
        input  in_pins, mode, div_ratio, div_load, cnt_clr,
        output out_pins, clk_div_out, edge_cnt
    );
endinterface

// File: rtl/cvs_io_bank.sv
// Synchronised GPIO bank (pin->out SYNC_STAGES+1 cycles) with pass/invert/hold/toggle modes and a
// reloadable 50% divided clock. Per-channel rising-edge counters exist only with CVS_EDGE_CNT_EN.
module cvs_io_bank #(
    parameter int N_CH        = 5,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 30,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    cvs_io_bank_if.slave io
);
    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_INV    = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] p_q;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] out_q;
    logic [N_CH-1:0] out_nxt;
    logic [N_CH-1:0] hold_q;
    logic [N_CH-1:0] hold_nxt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            p_q    <= '0;
        end else begin
            sync_q[0] <= io.in_pins;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            p_q <= s;
        end
    end

    // hold_q remembers that the channel was already in HOLD, so the capture happens only on entry
    always_comb begin
        out_nxt  = out_q;
        hold_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            hold_nxt[i] = (io.mode[2*i +: 2] == MODE_HOLD);
            case (io.mode[2*i +: 2])
                MODE_PASS:   out_nxt[i] = s[i];
                MODE_INV:    out_nxt[i] = ~s[i];
                MODE_HOLD:   if (!hold_q[i]) out_nxt[i] = s[i];
                MODE_TOGGLE: out_nxt[i] = out_q[i] ^ rise[i];
                default:     out_nxt[i] = out_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            hold_q <= '0;
        end else begin
            out_q  <= out_nxt;
            hold_q <= hold_nxt;
        end
    end

    assign io.out_pins = out_q;

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] ratio_act_q;
    logic [DIV_W-1:0] ratio_stg_q;
    logic [DIV_W-1:0] ratio_stg_nxt;
    logic [DIV_W-1:0] ratio_eff;
    logic             div_term;
    logic             div_q;

    assign ratio_eff     = (ratio_act_q == '0) ? DIV_W'(1) : ratio_act_q;
    assign div_term      = (div_cnt_q >= ratio_eff - DIV_W'(1));
    assign ratio_stg_nxt = io.div_load ? io.div_ratio : ratio_stg_q;

    // Active ratio only changes at the terminal count, so a half-period is never cut short
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            div_q       <= 1'b0;
            ratio_act_q <= DIV_W'(DIV_DEFAULT);
            ratio_stg_q <= DIV_W'(DIV_DEFAULT);
        end else begin
            ratio_stg_q <= ratio_stg_nxt;
            if (div_term) begin
                div_cnt_q   <= '0;
                div_q       <= ~div_q;
                ratio_act_q <= ratio_stg_nxt;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end

    assign io.clk_div_out = div_q;

`ifdef CVS_EDGE_CNT_EN
    logic [N_CH-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (io.cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (rise[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign io.edge_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = io.cnt_clr;
    assign io.edge_cnt    = '0;
`endif

endmodule

// File: tb/tb_cvs_io_bank.sv
// Bench for cvs_io_bank: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_cvs_io_bank;
    localparam int N_CH    = 5;
    localparam int SYNC    = 2;
    localparam int DW      = 8;
    localparam int DDEF    = 30;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cvs_io_bank_if #(.N_CH(N_CH), .DIV_W(DW), .CNT_W(CW)) io ();

    cvs_io_bank #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .DIV_W(DW), .DIV_DEFAULT(DDEF), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ph[k] = pin vector sampled k+1 edges before the upcoming edge
    logic [N_CH-1:0] ph [16];
    logic [N_CH-1:0] m_out;
    logic [N_CH-1:0] m_hold;
    int              m_cnt [N_CH];
    int              cyc;
    int              next_t;
    int              m_stg;
    int              m_act;
    logic            m_dv;

    function automatic int eff(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [N_CH*CW-1:0] m_cnt_vec();
        logic [N_CH*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[CW*i +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) ph[k] = '0;
        m_out  = '0;
        m_hold = '0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        cyc    = 0;
        next_t = DDEF;
        m_stg  = DDEF;
        m_act  = DDEF;
        m_dv   = 1'b0;
    endtask

    // Advance one clock: capture inputs, let the edge happen, update the model, return at negedge.
    task automatic tick();
        logic [2*N_CH-1:0] md;
        logic              ld;
        logic [DW-1:0]     rt;
        logic              clr;
        logic              sv;
        logic              rs;
        for (int k = 15; k > 0; k--) ph[k] = ph[k-1];
        ph[0] = io.in_pins;
        md    = io.mode;
        ld    = io.div_load;
        rt    = io.div_ratio;
        clr   = io.cnt_clr;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N_CH; i++) begin
            sv = ph[SYNC][i];
            rs = sv & ~ph[SYNC+1][i];
            case (md[2*i +: 2])
                2'b00: m_out[i] = sv;
                2'b01: m_out[i] = ~sv;
                2'b10: if (!m_hold[i]) m_out[i] = sv;
                default: m_out[i] = m_out[i] ^ rs;
            endcase
            m_hold[i] = (md[2*i +: 2] == 2'b10);
`ifdef CVS_EDGE_CNT_EN
            if (clr) m_cnt[i] = 0;
            else if (rs && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
`else
            if (clr && rs) m_cnt[i] = 0;
`endif
        end
        if (ld) m_stg = int'(rt);
        if (cyc == next_t) begin
            m_dv   = ~m_dv;
            m_act  = m_stg;
            next_t = cyc + eff(m_act);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int   rises[$];
        int   per;
        logic last;
        do_reset();
        vectors++;
        if (io.out_pins !== '0) begin miscompares++; $display("FAIL reset_out: got %b expected 0", io.out_pins); end
        vectors++;
        if (io.clk_div_out !== 1'b0) begin miscompares++; $display("FAIL reset_div: got %b expected 0", io.clk_div_out); end
        vectors++;
        if (io.edge_cnt !== '0) begin miscompares++; $display("FAIL reset_cnt: got %h expected 0", io.edge_cnt); end
        io.in_pins = N_CH'(21);
        for (int pass = 0; pass < 2; pass++) begin
            rises.delete();
            last = io.clk_div_out;
            repeat (100) begin
                tick();
                if (io.clk_div_out && !last) rises.push_back(cyc);
                last = io.clk_div_out;
            end
            per = (rises.size() >= 2) ? rises[1] - rises[0] : -1;
            vectors++;
            if (per !== 2 * DDEF) begin miscompares++; $display("FAIL div_default_period pass%0d: got %0d expected %0d", pass, per, 2 * DDEF); end
            vectors++;
            if (io.clk_div_out !== 1'b1) begin miscompares++; $display("FAIL div_phase_c100: got %b expected 1", io.clk_div_out); end
            vectors++;
            if (io.out_pins !== N_CH'(21)) begin miscompares++; $display("FAIL pass_all: got %b expected %b", io.out_pins, N_CH'(21)); end
            if (pass == 0) begin
                rst = 1'b1;
                #1;
                vectors++;
                if (io.out_pins !== '0) begin miscompares++; $display("FAIL midrst_out: got %b expected 0", io.out_pins); end
                vectors++;
                if (io.clk_div_out !== 1'b0) begin miscompares++; $display("FAIL midrst_div: got %b expected 0", io.clk_div_out); end
                vectors++;
                if (io.edge_cnt !== '0) begin miscompares++; $display("FAIL midrst_cnt: got %h expected 0", io.edge_cnt); end
                do_reset();
            end
        end
    endtask

    task automatic test_pass_inv();
        io.mode      = '0;
        io.mode[3:2] = 2'b01;
        io.in_pins   = '0;
        repeat (5) tick();
        io.in_pins[0] = 1'b1;
        io.in_pins[1] = 1'b1;
        tick();
        tick();
        vectors++;
        if (io.out_pins[1:0] !== 2'b10) begin miscompares++; $display("FAIL pass_inv_early: got %b expected 10", io.out_pins[1:0]); end
        tick();
        vectors++;
        if (io.out_pins[1:0] !== 2'b01) begin miscompares++; $display("FAIL pass_inv_lat3: got %b expected 01", io.out_pins[1:0]); end
        vectors++;
        if (io.out_pins !== m_out) begin miscompares++; $display("FAIL pass_inv_model: got %b expected %b", io.out_pins, m_out); end
    endtask

    task automatic test_hold();
        io.in_pins[2] = 1'b1;
        repeat (5) tick();
        io.mode[5:4] = 2'b10;
        tick();
        for (int n = 0; n < 10; n++) begin
            io.in_pins[2] = ~io.in_pins[2];
            tick();
            tick();
            vectors++;
            if (io.out_pins[2] !== 1'b1) begin miscompares++; $display("FAIL hold_frozen t%0d: got %b expected 1", n, io.out_pins[2]); end
        end
        io.mode[5:4]  = 2'b00;
        io.in_pins[2] = 1'b0;
        repeat (4) tick();
        vectors++;
        if (io.out_pins[2] !== 1'b0) begin miscompares++; $display("FAIL hold_exit0: got %b expected 0", io.out_pins[2]); end
        io.in_pins[2] = 1'b1;
        repeat (4) tick();
        vectors++;
        if (io.out_pins[2] !== 1'b1) begin miscompares++; $display("FAIL hold_exit1: got %b expected 1", io.out_pins[2]); end
        vectors++;
        if (io.out_pins !== m_out) begin miscompares++; $display("FAIL hold_model: got %b expected %b", io.out_pins, m_out); end
    endtask

    task automatic test_toggle();
        io.mode[7:6]  = 2'b00;
        io.in_pins[3] = 1'b0;
        repeat (4) tick();
        io.mode[7:6] = 2'b11;
        tick();
        tick();
        for (int n = 0; n < 5; n++) begin
            io.in_pins[3] = 1'b1;
            tick();
            tick();
            io.in_pins[3] = 1'b0;
            tick();
            tick();
            vectors++;
            if (io.out_pins[3] !== 1'((n + 1) & 1)) begin
                miscompares++;
                $display("FAIL toggle_edge%0d: got %b expected %0d", n, io.out_pins[3], (n + 1) & 1);
            end
        end
        repeat (4) tick();
        vectors++;
        if (io.out_pins[3] !== 1'b1) begin miscompares++; $display("FAIL toggle_final: got %b expected 1", io.out_pins[3]); end
        vectors++;
        if (io.out_pins !== m_out) begin miscompares++; $display("FAIL toggle_model: got %b expected %b", io.out_pins, m_out); end
    endtask

    task automatic test_divider();
        int   tq[$];
        int   exp_t[11];
        logic last;
        exp_t = '{30, 60, 64, 68, 69, 70, 71, 72, 73, 76, 79};
        do_reset();
        last = io.clk_div_out;
        while (cyc < 80) begin
            io.div_load  = (cyc == 40) || (cyc == 66) || (cyc == 72);
            io.div_ratio = (cyc == 40) ? DW'(4) : (cyc == 66) ? DW'(0) : DW'(3);
            tick();
            if (io.clk_div_out !== last) tq.push_back(cyc);
            last = io.clk_div_out;
            vectors++;
            if (io.clk_div_out !== m_dv) begin miscompares++; $display("FAIL div_model c%0d: got %b expected %b", cyc, io.clk_div_out, m_dv); end
        end
        io.div_load = 1'b0;
        vectors++;
        if (tq.size() != 11) begin miscompares++; $display("FAIL div_toggle_count: got %0d expected 11", tq.size()); end
        for (int k = 0; k < 11; k++) begin
            if (k < tq.size()) begin
                vectors++;
                if (tq[k] != exp_t[k]) begin miscompares++; $display("FAIL div_toggle%0d: got cycle %0d expected %0d", k, tq[k], exp_t[k]); end
            end
        end
    endtask

    task automatic test_edge_cnt();
        int exp4;
`ifdef CVS_EDGE_CNT_EN
        exp4 = CNT_MAX;
`else
        exp4 = 0;
`endif
        do_reset();
        io.mode = '0;
        repeat (300) begin
            io.in_pins[4] = 1'b1;
            tick();
            io.in_pins[4] = 1'b0;
            tick();
        end
        repeat (4) tick();
        vectors++;
        if (io.edge_cnt[CW*4 +: CW] !== CW'(exp4)) begin miscompares++; $display("FAIL cnt_saturate: got %0d expected %0d", io.edge_cnt[CW*4 +: CW], exp4); end
        vectors++;
        if (io.edge_cnt !== m_cnt_vec()) begin miscompares++; $display("FAIL cnt_model: got %h expected %h", io.edge_cnt, m_cnt_vec()); end
        io.cnt_clr = 1'b1;
        tick();
        io.cnt_clr = 1'b0;
        tick();
        vectors++;
        if (io.edge_cnt !== '0) begin miscompares++; $display("FAIL cnt_clear: got %h expected 0", io.edge_cnt); end
        io.in_pins[4] = 1'b1;
        tick();
        tick();
        io.cnt_clr = 1'b1;
        tick();
        io.cnt_clr = 1'b0;
        tick();
        vectors++;
        if (io.edge_cnt[CW*4 +: CW] !== '0) begin miscompares++; $display("FAIL cnt_clr_vs_edge: got %0d expected 0", io.edge_cnt[CW*4 +: CW]); end
        io.in_pins[4] = 1'b0;
        repeat (2) tick();
        io.in_pins[4] = 1'b1;
        repeat (4) tick();
        vectors++;
        if (io.edge_cnt[CW*4 +: CW] !== CW'(exp4 == 0 ? 0 : 1)) begin
            miscompares++;
            $display("FAIL cnt_one_edge: got %0d expected %0d", io.edge_cnt[CW*4 +: CW], exp4 == 0 ? 0 : 1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            io.in_pins = N_CH'($urandom);
            if (n % 25 == 0) io.mode = (2*N_CH)'($urandom);
            io.div_load  = ($urandom_range(0, 15) == 0);
            io.div_ratio = DW'($urandom_range(0, 6));
            io.cnt_clr   = ($urandom_range(0, 31) == 0);
            tick();
            vectors++;
            if (io.out_pins !== m_out) begin miscompares++; $display("FAIL rand_out c%0d: got %b expected %b", cyc, io.out_pins, m_out); end
            vectors++;
            if (io.clk_div_out !== m_dv) begin miscompares++; $display("FAIL rand_div c%0d: got %b expected %b", cyc, io.clk_div_out, m_dv); end
            vectors++;
            if (io.edge_cnt !== m_cnt_vec()) begin miscompares++; $display("FAIL rand_cnt c%0d: got %h expected %h", cyc, io.edge_cnt, m_cnt_vec()); end
        end
        io.div_load = 1'b0;
        io.cnt_clr  = 1'b0;
    endtask

    initial begin
        io.in_pins   = '0;
        io.mode      = '0;
        io.div_ratio = '0;
        io.div_load  = 1'b0;
        io.cnt_clr   = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        test_reset();
        test_pass_inv();
        test_hold();
        test_toggle();
        test_divider();
        test_edge_cnt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
